// File: rtl/mem_access_stage_if.sv
// Data-memory request/response bundle between the MEM stage and data memory.
// The stage drives the request side; memory answers with a one-cycle ack pulse.
interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues lw/sw to data memory, stalls until ack or
// timeout, and loads the M/W latch with results, aborts or bubbles.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        xm_ALU_out,
  input  logic [31:0]        xm_B,
  input  logic [31:0]        xm_IR,
  input  logic               xm_exception,
  mem_access_stage_if.master mem,
  output logic               mem_stall,
  output logic [31:0]        mw_O,
  output logic [31:0]        mw_D,
  output logic [31:0]        mw_IR,
  output logic               mw_exception
);

  localparam int CW =
    (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
  localparam logic [4:0] OP_LW = 5'b01000;
  localparam logic [4:0] OP_SW = 5'b00111;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   ir_q, ir_d;
  logic          sw_q, sw_d;
  logic [31:0]   o_q, o_d;
  logic [31:0]   d_q, d_d;
  logic [31:0]   irw_q, irw_d;
  logic          exc_q, exc_d;
  logic          stall;
  logic          is_lw, is_sw, mem_op;

  assign is_lw  = (xm_IR[31:27] == OP_LW);
  assign is_sw  = (xm_IR[31:27] == OP_SW);
  assign mem_op = (is_lw | is_sw) & ~xm_exception;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ir_d    = ir_q;
    sw_d    = sw_q;
    // M/W defaults to a bubble; stalled edges keep it
    o_d     = '0;
    d_d     = '0;
    irw_d   = '0;
    exc_d   = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_op) begin
          stall   = 1'b1;
          addr_d  = xm_ALU_out;
          wdata_d = xm_B;
          ir_d    = xm_IR;
          sw_d    = is_sw;
          cnt_d   = '0;
          state_d = BUSY;
        end else begin
          o_d   = xm_ALU_out;
          irw_d = xm_IR;
          exc_d = xm_exception;
        end
      end
      BUSY: begin
        if (mem.mem_ack) begin
          o_d     = addr_q;
          d_d     = sw_q ? 32'd0 : mem.mem_rdata;
          irw_d   = ir_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == TMAX) begin
          o_d     = addr_q;
          irw_d   = ir_q;
          exc_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ir_q    <= '0;
      sw_q    <= 1'b0;
      o_q     <= '0;
      d_q     <= '0;
      irw_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ir_q    <= ir_d;
      sw_q    <= sw_d;
      o_q     <= o_d;
      d_q     <= d_d;
      irw_q   <= irw_d;
      exc_q   <= exc_d;
    end
  end

  // Stall is combinational on X/M, so gate it while reset is held
  assign mem_stall     = stall & reset;
  assign mem.mem_req   = (state_q == BUSY);
  assign mem.mem_we    = (state_q == BUSY) & sw_q;
  assign mem.mem_addr  = (state_q == BUSY) ? addr_q : 32'd0;
  assign mem.mem_wdata = (state_q == BUSY) ? wdata_q : 32'd0;
  assign mw_O          = o_q;
  assign mw_D          = d_q;
  assign mw_IR         = irw_q;
  assign mw_exception  = exc_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: transaction-level model plus directed
// lw/sw/timeout/reset scenarios with literal expectations.
module tb_mem_access_stage;
  localparam int unsigned TMO = 4;
  localparam logic [31:0] LW = 32'h4000_0000;
  localparam logic [31:0] SW = 32'h3800_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] xm_ALU_out = '0;
  logic [31:0] xm_B = '0;
  logic [31:0] xm_IR = '0;
  logic        xm_exception = 1'b0;
  logic        mem_stall;
  logic [31:0] mw_O, mw_D, mw_IR;
  logic        mw_exception;

  mem_access_stage_if bus ();

  mem_access_stage #(.TIMEOUT(TMO)) dut (
    .clock        (clock),
    .reset        (reset),
    .xm_ALU_out   (xm_ALU_out),
    .xm_B         (xm_B),
    .xm_IR        (xm_IR),
    .xm_exception (xm_exception),
    .mem          (bus),
    .mem_stall    (mem_stall),
    .mw_O         (mw_O),
    .mw_D         (mw_D),
    .mw_IR        (mw_IR),
    .mw_exception (mw_exception)
  );

  always #5 clock = ~clock;

  int nerr = 0;
  int nchk = 0;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t",
               n, act, exp, $time);
    end
  endtask

  function automatic bit is_memop(input logic [31:0] ir,
                                  input logic e);
    return !e && (ir[31:27] == 5'b01000 ||
                  ir[31:27] == 5'b00111);
  endfunction

  // Model: one outstanding access, waited cycles, and the retired M/W value
  bit          m_pend, m_sw;
  int          m_wait;
  logic [31:0] m_addr, m_wd, m_ir;
  logic [31:0] e_O, e_D, e_IR;
  logic        e_exc;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_pend <= 0; m_sw <= 0; m_wait <= 0;
      m_addr <= '0; m_wd <= '0; m_ir <= '0;
      e_O <= '0; e_D <= '0; e_IR <= '0; e_exc <= 0;
    end else if (!m_pend) begin
      if (is_memop(xm_IR, xm_exception)) begin
        m_pend <= 1; m_wait <= 0;
        m_addr <= xm_ALU_out; m_wd <= xm_B; m_ir <= xm_IR;
        m_sw <= (xm_IR[31:27] == 5'b00111);
        e_O <= '0; e_D <= '0; e_IR <= '0; e_exc <= 0;
      end else begin
        e_O <= xm_ALU_out; e_D <= '0;
        e_IR <= xm_IR; e_exc <= xm_exception;
      end
    end else if (bus.mem_ack) begin
      e_O <= m_addr; e_IR <= m_ir; e_exc <= 0;
      e_D <= m_sw ? 32'd0 : bus.mem_rdata;
      m_pend <= 0;
    end else if (m_wait == int'(TMO)) begin
      e_O <= m_addr; e_D <= '0; e_IR <= m_ir; e_exc <= 1;
      m_pend <= 0;
    end else begin
      m_wait <= m_wait + 1;
      e_O <= '0; e_D <= '0; e_IR <= '0; e_exc <= 0;
    end
  end

  always @(negedge clock) begin
    logic xs;
    xs = reset && (m_pend ? (!bus.mem_ack && m_wait != int'(TMO))
                          : is_memop(xm_IR, xm_exception));
    chk("stall", 32'(mem_stall), 32'(xs));
    chk("req", 32'(bus.mem_req), 32'(m_pend));
    chk("we", 32'(bus.mem_we), 32'(m_pend && m_sw));
    chk("addr", bus.mem_addr, m_pend ? m_addr : 32'd0);
    chk("wdata", bus.mem_wdata, m_pend ? m_wd : 32'd0);
    chk("mw_O", mw_O, e_O);
    chk("mw_D", mw_D, e_D);
    chk("mw_IR", mw_IR, e_IR);
    chk("mw_exc", 32'(mw_exception), 32'(e_exc));
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one X/M instruction, hold it while stalled, ack on BUSY cycle ack_at
  task automatic run(input logic [31:0] a, b, ir,
                     input logic e, input int ack_at,
                     input logic [31:0] rd,
                     output int nst, output int nreq,
                     output logic we_s,
                     output logic [31:0] wd_s, ad_s);
    int busy_n;
    bit done;
    busy_n = 0; done = 0; nst = 0; nreq = 0;
    we_s = 0; wd_s = '0; ad_s = '0;
    xm_ALU_out = a; xm_B = b; xm_IR = ir;
    xm_exception = e; bus.mem_ack = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (bus.mem_req) begin
        if (busy_n == ack_at) begin
          bus.mem_ack = 1; bus.mem_rdata = rd;
        end
        busy_n++;
      end
      @(negedge clock);
      if (mem_stall) nst++;
      if (bus.mem_req) begin
        nreq++; we_s = bus.mem_we;
        wd_s = bus.mem_wdata; ad_s = bus.mem_addr;
      end
      done = !mem_stall;
      step();
      bus.mem_ack = 0;
    end
    chk("run_bound", 32'(done), 32'd1);
  endtask

  int nst, nreq;
  logic we_s;
  logic [31:0] wd_s, ad_s;

  initial begin
    bus.mem_ack = 0;
    bus.mem_rdata = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_mw_O", mw_O, 32'd0);
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    reset = 1;
    step();

    run(32'h15, 0, 32'h0000_0123, 0, -1, 0,
        nst, nreq, we_s, wd_s, ad_s);
    chk("pt_O", mw_O, 32'h15);
    chk("pt_IR", mw_IR, 32'h0000_0123);
    chk("pt_nst", nst, 0);
    chk("pt_nreq", nreq, 0);

    run(32'h40, 0, LW | 32'h5, 0, 3, 32'hDEAD_BEEF,
        nst, nreq, we_s, wd_s, ad_s);
    chk("lw_nst", nst, 4);
    chk("lw_nreq", nreq, 4);
    chk("lw_we", 32'(we_s), 0);
    chk("lw_addr", ad_s, 32'h40);
    chk("lw_D", mw_D, 32'hDEAD_BEEF);
    chk("lw_O", mw_O, 32'h40);
    chk("lw_IR", mw_IR, LW | 32'h5);

    run(32'h99, 0, 32'h0800_0000, 0, -1, 0,
        nst, nreq, we_s, wd_s, ad_s);
    chk("b2b_nst", nst, 0);
    chk("b2b_O", mw_O, 32'h99);

    run(32'h10, 32'h1234, SW, 0, 0, 32'hFFFF_FFFF,
        nst, nreq, we_s, wd_s, ad_s);
    chk("sw_we", 32'(we_s), 1);
    chk("sw_wdata", wd_s, 32'h1234);
    chk("sw_nst", nst, 1);
    chk("sw_D", mw_D, 0);
    chk("sw_O", mw_O, 32'h10);
    chk("sw_exc", 32'(mw_exception), 0);

    run(32'h80, 0, LW, 0, -1, 32'h5555,
        nst, nreq, we_s, wd_s, ad_s);
    chk("to_nst", nst, 5);
    chk("to_nreq", nreq, 5);
    chk("to_exc", 32'(mw_exception), 1);
    chk("to_O", mw_O, 32'h80);
    chk("to_D", mw_D, 0);
    chk("to_req_fall", 32'(bus.mem_req), 0);

    run(32'h84, 0, LW, 0, 4, 32'hCAFE,
        nst, nreq, we_s, wd_s, ad_s);
    chk("ab_nst", nst, 5);
    chk("ab_exc", 32'(mw_exception), 0);
    chk("ab_D", mw_D, 32'hCAFE);

    run(32'h40, 0, LW, 1, -1, 0,
        nst, nreq, we_s, wd_s, ad_s);
    chk("ex_nreq", nreq, 0);
    chk("ex_exc", 32'(mw_exception), 1);
    chk("ex_O", mw_O, 32'h40);

    xm_ALU_out = 32'h77; xm_IR = '0; xm_exception = 0;
    bus.mem_ack = 1; bus.mem_rdata = 32'hABCD;
    step();
    bus.mem_ack = 0;
    chk("idle_ack_O", mw_O, 32'h77);
    chk("idle_ack_D", mw_D, 0);
    chk("idle_ack_req", 32'(bus.mem_req), 0);

    xm_ALU_out = 32'h200; xm_IR = LW;
    step();
    step();
    chk("mid_req", 32'(bus.mem_req), 1);
    chk("mid_stall", 32'(mem_stall), 1);
    #2;
    reset = 0;
    #1;
    chk("ar_req", 32'(bus.mem_req), 0);
    chk("ar_stall", 32'(mem_stall), 0);
    chk("ar_addr", bus.mem_addr, 0);
    chk("ar_O", mw_O, 0);
    chk("ar_IR", mw_IR, 0);
    xm_ALU_out = 32'h5; xm_IR = '0;
    step();
    reset = 1;
    bus.mem_ack = 1; bus.mem_rdata = 32'h1111;
    step();
    bus.mem_ack = 0;
    chk("rel_D", mw_D, 0);
    chk("rel_O", mw_O, 32'h5);
    chk("rel_IR", mw_IR, 0);
    step();
    chk("rel_req", 32'(bus.mem_req), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
